pipe_score_tracker: RTL and testbench

//  Consumer end of the pipe position interface: samples the X/Y of every pipe object and the bird once per frame_clk.

---
 rtl/flappy_pkg.sv | 34 +++
 rtl/pipe_hit_check.sv | 44 ++++
 rtl/pipe_score_tracker.sv | 166 ++++++++++++++++
 tb/tb_pipe_score_tracker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// ============================================================================
// flappy_pkg : shared game-state type, key codes and score helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    localparam logic [7:0] KEY_FLAP    = 8'h1A;
    localparam logic [7:0] KEY_RESTART = 8'h15;

    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;
    localparam int SCORE_W      = 27;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // The carry out of the widened add means the true sum passed SCORE_MAX.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [7:0]         b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {{(SCORE_W-7){1'b0}}, b};
        return s[SCORE_W] ? SCORE_MAX : s[SCORE_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hit_check.sv
// ============================================================================
// pipe_hit_check : one pipe versus bird bounds -> hit / pass / rearm
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hit_check #(
    parameter int PIPE_W = 26,
    parameter int GAP_H  = 60
) (
    input  logic [9:0]  pipe_x,
    input  logic [9:0]  pipe_y,
    input  logic [10:0] bird_l,
    input  logic [10:0] bird_r,
    input  logic [10:0] bird_t,
    input  logic [10:0] bird_b,
    output logic        hit,
    output logic        pass,
    output logic        rearm
);

    localparam logic [10:0] C_PIPE_W = 11'(PIPE_W);
    localparam logic [10:0] C_GAP_H  = 11'(GAP_H);

    logic [10:0] w_pipe_l;
    logic [10:0] w_pipe_r;
    logic [10:0] w_gap_t;
    logic [10:0] w_gap_b;

    always_comb begin
        w_pipe_l = {1'b0, pipe_x};
        w_pipe_r = w_pipe_l + C_PIPE_W;
        w_gap_t  = ({1'b0, pipe_y} > C_GAP_H) ? ({1'b0, pipe_y} - C_GAP_H) : 11'd0;
        w_gap_b  = {1'b0, pipe_y} + C_GAP_H;

        hit   = (w_pipe_l <= bird_r) && (w_pipe_r >= bird_l) &&
                ((bird_t < w_gap_t) || (bird_b > w_gap_b));
        pass  = (w_pipe_r < bird_l);
        rearm = (w_pipe_l > bird_r);
    end

endmodule

`default_nettype wire

// File: rtl/pipe_score_tracker.sv
// ============================================================================
// pipe_score_tracker : game FSM, collision/clear tracking and saturating score
// Optional macro HIGH_SCORE_EN builds the best-score register.   Rev 1.0
// ============================================================================
`default_nettype none

module pipe_score_tracker
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = 4,
    parameter int PIPE_W    = 26,
    parameter int GAP_H     = 60,
    parameter int Y_FLOOR   = SCREEN_Y_MAX
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic [7:0]              keycode,
    input  logic [9:0]              BirdX,
    input  logic [9:0]              BirdY,
    input  logic [9:0]              BirdS,
    input  logic [NUM_PIPES*10-1:0] PipeX,
    input  logic [NUM_PIPES*10-1:0] PipeY,
    output logic [SCORE_W-1:0]      score,
    output logic                    score_pulse,
    output logic                    game_over,
    output logic                    play,
    output logic [SCORE_W-1:0]      high_score
);

    localparam int CNT_W = $clog2(NUM_PIPES + 1);

    logic [10:0] w_bird_l;
    logic [10:0] w_bird_r;
    logic [10:0] w_bird_t;
    logic [10:0] w_bird_b;

    assign w_bird_l = (BirdX > BirdS) ? ({1'b0, BirdX} - {1'b0, BirdS}) : 11'd0;
    assign w_bird_r = {1'b0, BirdX} + {1'b0, BirdS};
    assign w_bird_t = {1'b0, BirdY} - {1'b0, BirdS};
    assign w_bird_b = {1'b0, BirdY} + {1'b0, BirdS};

    logic [NUM_PIPES-1:0] w_hit;
    logic [NUM_PIPES-1:0] w_pass;
    logic [NUM_PIPES-1:0] w_rearm;

    generate
        for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
            pipe_hit_check #(
                .PIPE_W (PIPE_W),
                .GAP_H  (GAP_H)
            ) u_chk (
                .pipe_x (PipeX[10*gi +: 10]),
                .pipe_y (PipeY[10*gi +: 10]),
                .bird_l (w_bird_l),
                .bird_r (w_bird_r),
                .bird_t (w_bird_t),
                .bird_b (w_bird_b),
                .hit    (w_hit[gi]),
                .pass   (w_pass[gi]),
                .rearm  (w_rearm[gi])
            );
        end
    endgenerate

    game_state_t          state_q, state_d;
    logic [NUM_PIPES-1:0] passed_q, passed_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 pulse_q, pulse_d;
    logic                 play_q, play_d;
    logic                 over_q, over_d;
    logic [CNT_W-1:0]     w_new_cnt;
    logic                 w_die;

    always_comb begin
        w_new_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_new_cnt = w_new_cnt + CNT_W'(w_pass[i] & ~passed_q[i]);
        end
        w_die = (|w_hit) || (w_bird_b >= 11'(Y_FLOOR));
    end

    always_comb begin
        state_d  = state_q;
        passed_d = passed_q;
        score_d  = score_q;
        pulse_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (keycode == KEY_FLAP) begin
                    state_d  = PLAY;
                    score_d  = '0;
                    passed_d = w_pass;
                end
            end
            PLAY: begin
                // A collision on the same frame as a clear takes precedence.
                if (w_die) begin
                    state_d = DEAD;
                end else begin
                    passed_d = (passed_q & ~w_rearm) | w_pass;
                    if ((w_new_cnt != '0) && (score_q != SCORE_MAX)) begin
                        score_d = sat_add(score_q, 8'(w_new_cnt));
                        pulse_d = 1'b1;
                    end
                end
            end
            DEAD: begin
                if (keycode == KEY_RESTART) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        play_d = (state_q == PLAY);
        over_d = (state_q == DEAD);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            passed_q <= '0;
            score_q  <= '0;
            pulse_q  <= 1'b0;
            play_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            passed_q <= passed_d;
            score_q  <= score_d;
            pulse_q  <= pulse_d;
            play_q   <= play_d;
            over_q   <= over_d;
        end
    end

    assign score       = score_q;
    assign score_pulse = pulse_q;
    assign play        = play_q;
    assign game_over   = over_q;

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q, high_d;

    always_comb begin
        high_d = high_q;
        if ((state_q == PLAY) && (state_d == DEAD) && (score_q > high_q)) begin
            high_d = score_q;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign high_score = high_q;
`else
    assign high_score = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_score_tracker.sv
// ============================================================================
// tb_pipe_score_tracker : vector table plus directed corner sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_score_tracker;

    localparam logic [9:0]  P    = 10'd700;
    localparam logic [26:0] SMAX = 27'h7FFFFFF;
`ifdef HIGH_SCORE_EN
    localparam logic [26:0] HS_A = 27'd5;
    localparam logic [26:0] HS_B = 27'h7FFFFFF;
`else
    localparam logic [26:0] HS_A = 27'd0;
    localparam logic [26:0] HS_B = 27'd0;
`endif

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic [7:0]  keycode;
    logic [9:0]  BirdX, BirdY, BirdS;
    logic [39:0] PipeX, PipeY;
    logic [26:0] score, high_score;
    logic        score_pulse, game_over, play;

    pipe_score_tracker dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .BirdX       (BirdX),
        .BirdY       (BirdY),
        .BirdS       (BirdS),
        .PipeX       (PipeX),
        .PipeY       (PipeY),
        .score       (score),
        .score_pulse (score_pulse),
        .game_over   (game_over),
        .play        (play),
        .high_score  (high_score)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [7:0]  key;
        logic [9:0]  by;
        logic [39:0] px;
        logic [9:0]  py0;
        logic [26:0] e_score;
        logic        e_pulse;
        logic        e_play;
        logic        e_over;
        logic [26:0] e_high;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(input logic [7:0] key, input logic [9:0] by,
                                input logic [9:0] p0, input logic [9:0] p1,
                                input logic [9:0] p2, input logic [9:0] p3,
                                input logic [9:0] py0, input logic [26:0] sc,
                                input logic pu, input logic pl, input logic ov,
                                input logic [26:0] hs);
        vec_t v;
        v.key = key; v.by = by; v.px = {p3, p2, p1, p0}; v.py0 = py0;
        v.e_score = sc; v.e_pulse = pu; v.e_play = pl; v.e_over = ov; v.e_high = hs;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic [7:0] key, input logic [9:0] by,
                         input logic [39:0] px, input logic [9:0] py0);
        keycode = key;
        BirdY   = by;
        PipeX   = px;
        PipeY   = {10'd240, 10'd240, 10'd240, py0};
    endtask

    task automatic step();
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    initial begin
        // key, BirdY, pipe0..3 X, pipe0 Y, score, pulse, play, over, high
        vecs.push_back(mk(8'h1A, 240, P,   P,  P,  P,  240, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'h00, 240, P,   P,  P,  P,  240, 0, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 120, P,  P,  P,  240, 0, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 90,  P,  P,  P,  240, 0, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 70,  P,  P,  P,  240, 0, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 69,  P,  P,  P,  240, 1, 1, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 65,  P,  P,  P,  240, 1, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 60,  P,  P,  P,  240, 1, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, P,   P,  P,  P,  240, 1, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 69,  P,  P,  P,  240, 2, 1, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 60,  P,  P,  P,  240, 2, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, P,   P,  P,  P,  240, 2, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 80,  80, P,  P,  240, 2, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 60,  60, P,  P,  240, 4, 1, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 60,  60, P,  P,  240, 4, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 60,  60, 80, P,  240, 4, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 60,  60, 60, P,  240, 5, 1, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, P,   P,  P,  P,  240, 5, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 98,  P,  P,  P,  240, 5, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 240, 98,  P,  P,  P,  300, 5, 0, 1, 0, HS_A));
        vecs.push_back(mk(8'h1A, 240, 98,  P,  P,  60, 300, 5, 0, 0, 1, HS_A));
        vecs.push_back(mk(8'h15, 240, 98,  P,  P,  60, 300, 5, 0, 0, 1, HS_A));
        vecs.push_back(mk(8'h00, 240, P,   P,  P,  60, 240, 5, 0, 0, 0, HS_A));
        vecs.push_back(mk(8'h1A, 240, P,   P,  P,  60, 240, 0, 0, 0, 0, HS_A));
        vecs.push_back(mk(8'h00, 240, P,   P,  P,  60, 240, 0, 0, 1, 0, HS_A));
        vecs.push_back(mk(8'h00, 240, P,   P,  P,  50, 240, 0, 0, 1, 0, HS_A));

        Reset_n = 1'b0;
        BirdX   = 10'd100;
        BirdS   = 10'd4;
        drive(8'h00, 240, {P, P, P, P}, 240);
        #12;
        check("rst_score", 32'(score), 0);
        check("rst_pulse", 32'(score_pulse), 0);
        check("rst_play", 32'(play), 0);
        check("rst_over", 32'(game_over), 0);
        check("rst_high", 32'(high_score), 0);
        @(negedge frame_clk);
        Reset_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].key, vecs[i].by, vecs[i].px, vecs[i].py0);
            step();
            check($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].e_score));
            check($sformatf("v%0d_pulse", i), 32'(score_pulse), 32'(vecs[i].e_pulse));
            check($sformatf("v%0d_play", i), 32'(play), 32'(vecs[i].e_play));
            check($sformatf("v%0d_over", i), 32'(game_over), 32'(vecs[i].e_over));
            check($sformatf("v%0d_high", i), 32'(high_score), 32'(vecs[i].e_high));
        end

        // Saturation: preload one below the ceiling, then clear two pipes at once.
        force dut.score_q = 27'h7FFFFFE;
        #1;
        release dut.score_q;
        drive(8'h00, 240, {P, P, 10'd60, 10'd60}, 240);
        step();
        check("sat_score", 32'(score), 32'(SMAX));
        check("sat_pulse", 32'(score_pulse), 1);
        drive(8'h00, 240, {P, 10'd60, 10'd60, 10'd60}, 240);
        step();
        check("sat_hold_score", 32'(score), 32'(SMAX));
        check("sat_hold_pulse", 32'(score_pulse), 0);

        // Floor: bottom edge 478 survives, 479 dies.
        drive(8'h00, 474, {P, P, P, P}, 240);
        step();
        step();
        check("floor478_play", 32'(play), 1);
        check("floor478_over", 32'(game_over), 0);
        drive(8'h00, 475, {P, P, P, P}, 240);
        step();
        step();
        check("floor479_over", 32'(game_over), 1);
        check("floor479_high", 32'(high_score), 32'(HS_B));
        check("floor479_score", 32'(score), 32'(SMAX));

        // Restart, score once, then reset asynchronously mid-PLAY.
        drive(8'h15, 240, {P, P, P, P}, 240);
        step();
        drive(8'h1A, 240, {P, P, P, P}, 240);
        step();
        check("restart_score", 32'(score), 0);
        drive(8'h00, 240, {P, P, P, 10'd69}, 240);
        step();
        check("mid_score", 32'(score), 1);
        check("mid_play", 32'(play), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_score", 32'(score), 0);
        check("arst_pulse", 32'(score_pulse), 0);
        check("arst_play", 32'(play), 0);
        check("arst_over", 32'(game_over), 0);
        check("arst_high", 32'(high_score), 0);
        @(negedge frame_clk);
        Reset_n = 1'b1;
        drive(8'h00, 240, {P, P, P, P}, 240);
        step();
        step();
        check("post_rst_play", 32'(play), 0);
        check("post_rst_score", 32'(score), 0);
        drive(8'h1A, 240, {P, P, P, P}, 240);
        step();
        drive(8'h00, 240, {P, P, P, P}, 240);
        step();
        check("post_rst_start", 32'(play), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
